// File: rtl/arch_map_table_release_pkg.sv
// Shared rename-side definitions for the retirement architectural map table.
// Holds table geometry, the restore FSM encoding and the release lane record.
package arch_map_table_release_pkg;

   localparam int SIZE_ARCH         = 32;
   localparam int SIZE_ARCH_LOG     = 5;
   localparam int SIZE_PHYSICAL_LOG = 7;
   localparam int AMT_LANES         = 4;

   typedef logic [SIZE_ARCH_LOG-1:0]     arch_t;
   typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_t;

   typedef enum logic [1:0] {
      AMT_IDLE,
      AMT_RESTORE,
      AMT_DONE
   } amt_state_e;

   typedef struct packed {
      logic  valid;
      phys_t preg;
   } release_lane_t;

endpackage

// File: rtl/arch_map_table_release_bypass_select.sv
// Four-lane same-arch priority matcher: for each lane, finds the youngest older
// valid lane that targets the same architectural register.
module amt_bypass_select
   import arch_map_table_release_pkg::*;
(
   input  logic [AMT_LANES-1:0]                    valid_i,
   input  logic [AMT_LANES-1:0][SIZE_ARCH_LOG-1:0] arch_i,
   output logic [AMT_LANES-1:0]                    hit_o,
   output logic [AMT_LANES-1:0][1:0]               src_o
);

   // Ascending scan of older lanes so the last match (youngest older) wins.
   always_comb begin
      hit_o = '0;
      src_o = '0;
      for (int n = 1; n < AMT_LANES; n++) begin
         for (int m = 0; m < n; m++) begin
            if (valid_i[n] && valid_i[m] && (arch_i[n] == arch_i[m])) begin
               hit_o[n] = 1'b1;
               src_o[n] = 2'(m);
            end
         end
      end
   end

endmodule

// File: rtl/arch_map_table_release.sv
// Retirement architectural map table: records committed destinations, releases
// the superseded physical tags to the free list and streams the table on recovery.
module arch_map_table_release
   import arch_map_table_release_pkg::*;
#(
   parameter int COMMIT_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         commitValid0_i,
   input  logic                         commitValid1_i,
   input  logic                         commitValid2_i,
   input  logic                         commitValid3_i,
   input  logic                         commitHasDest0_i,
   input  logic                         commitHasDest1_i,
   input  logic                         commitHasDest2_i,
   input  logic                         commitHasDest3_i,
   input  logic [SIZE_ARCH_LOG-1:0]     commitArch0_i,
   input  logic [SIZE_ARCH_LOG-1:0]     commitArch1_i,
   input  logic [SIZE_ARCH_LOG-1:0]     commitArch2_i,
   input  logic [SIZE_ARCH_LOG-1:0]     commitArch3_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhys0_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhys1_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhys2_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhys3_i,
   output logic                         commitReady_o,
   input  logic                         recover_i,
   output logic                         releaseValid0_o,
   output logic                         releaseValid1_o,
   output logic                         releaseValid2_o,
   output logic                         releaseValid3_o,
   output logic [SIZE_PHYSICAL_LOG-1:0] releaseReg0_o,
   output logic [SIZE_PHYSICAL_LOG-1:0] releaseReg1_o,
   output logic [SIZE_PHYSICAL_LOG-1:0] releaseReg2_o,
   output logic [SIZE_PHYSICAL_LOG-1:0] releaseReg3_o,
   output logic                         restoreValid_o,
   output logic [SIZE_ARCH_LOG-1:0]     restoreArch_o,
   output logic [SIZE_PHYSICAL_LOG-1:0] restorePhys_o,
   output logic                         restoreDone_o
);

   logic [AMT_LANES-1:0]                        commit_valid;
   logic [AMT_LANES-1:0]                        commit_has_dest;
   logic [AMT_LANES-1:0]                        eff;
   logic [AMT_LANES-1:0][SIZE_ARCH_LOG-1:0]     commit_arch;
   logic [AMT_LANES-1:0][SIZE_PHYSICAL_LOG-1:0] commit_phys;
   logic                                        commit_ready;
   logic                                        restore_valid;
   logic                                        restore_done;

   logic [AMT_LANES-1:0]      byp_hit;
   logic [AMT_LANES-1:0][1:0] byp_src;
   logic [AMT_LANES-1:0]      superseded;

   phys_t                          table_q [SIZE_ARCH];
   phys_t                          table_d [SIZE_ARCH];
   release_lane_t [AMT_LANES-1:0]  release_q;
   release_lane_t [AMT_LANES-1:0]  release_d;
   amt_state_e                     state_q;
   amt_state_e                     state_d;
   arch_t                          idx_q;
   arch_t                          idx_d;

   assign commit_valid    = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i};
   assign commit_has_dest = {commitHasDest3_i, commitHasDest2_i, commitHasDest1_i, commitHasDest0_i};
   assign commit_arch     = {commitArch3_i, commitArch2_i, commitArch1_i, commitArch0_i};
   assign commit_phys     = {commitPhys3_i, commitPhys2_i, commitPhys1_i, commitPhys0_i};
   assign eff             = commit_valid & commit_has_dest & {AMT_LANES{commit_ready}};

   amt_bypass_select u_bypass (
      .valid_i (eff),
      .arch_i  (commit_arch),
      .hit_o   (byp_hit),
      .src_o   (byp_src)
   );

   // A lane is superseded when some younger lane names it as its bypass source.
   always_comb begin
      superseded = '0;
      for (int n = 0; n < AMT_LANES; n++) begin
         if (byp_hit[n]) superseded[byp_src[n]] = 1'b1;
      end
   end

   always_comb begin
      table_d = table_q;
      for (int n = 0; n < AMT_LANES; n++) begin
         if (eff[n] && !superseded[n]) table_d[commit_arch[n]] = commit_phys[n];
      end
   end

   always_comb begin
      release_d = '0;
      for (int n = 0; n < AMT_LANES; n++) begin
         if (eff[n]) begin
            release_d[n].valid = 1'b1;
            release_d[n].preg  = byp_hit[n] ? commit_phys[byp_src[n]] : table_q[commit_arch[n]];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      commit_ready  = 1'b0;
      restore_valid = 1'b0;
      restore_done  = 1'b0;
      case (state_q)
         AMT_IDLE: begin
            commit_ready = 1'b1;
            if (recover_i) begin
               state_d = AMT_RESTORE;
               idx_d   = '0;
            end
         end
         AMT_RESTORE: begin
            restore_valid = 1'b1;
            if (recover_i) begin
               idx_d = '0;
            end else if (idx_q == arch_t'(SIZE_ARCH - 1)) begin
               state_d = AMT_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + arch_t'(1);
            end
         end
         AMT_DONE: begin
            commit_ready = 1'b1;
            restore_done = 1'b1;
            state_d      = recover_i ? AMT_RESTORE : AMT_IDLE;
            idx_d        = '0;
         end
         default: begin
            state_d = AMT_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= AMT_IDLE;
         idx_q     <= '0;
         release_q <= '0;
         for (int i = 0; i < SIZE_ARCH; i++) table_q[i] <= phys_t'(i);
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         release_q <= release_d;
         table_q   <= table_d;
      end
   end

   // A committing tag must come from the free list, never from a live mapping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (COMMIT_WIDTH == AMT_LANES)
            else $error("commit width must be %0d", AMT_LANES);
         for (int n = 0; n < AMT_LANES; n++) begin
            for (int i = 0; i < SIZE_ARCH; i++) begin
               assert (!(eff[n] && (table_q[i] == commit_phys[n])))
                  else $error("lane %0d commits live tag %0d", n, commit_phys[n]);
            end
         end
      end
   end

   assign commitReady_o   = commit_ready;
   assign releaseValid0_o = release_q[0].valid;
   assign releaseValid1_o = release_q[1].valid;
   assign releaseValid2_o = release_q[2].valid;
   assign releaseValid3_o = release_q[3].valid;
   assign releaseReg0_o   = release_q[0].preg;
   assign releaseReg1_o   = release_q[1].preg;
   assign releaseReg2_o   = release_q[2].preg;
   assign releaseReg3_o   = release_q[3].preg;
   assign restoreValid_o  = restore_valid;
   assign restoreArch_o   = restore_valid ? idx_q : '0;
   assign restorePhys_o   = restore_valid ? table_q[idx_q] : '0;
   assign restoreDone_o   = restore_done;

endmodule

// File: tb/tb_arch_map_table_release.sv
// Self-checking bench: directed literal scenarios plus randomized traffic checked
// every cycle against a sequential-retire reference model with a free-list queue.
module tb_arch_map_table_release;
   import arch_map_table_release_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       recover = 1'b0;
   logic [3:0] cv = '0;
   logic [3:0] ch = '0;
   logic [4:0] ca [4];
   logic [6:0] cp [4];

   logic       commit_ready;
   logic       rv [4];
   logic [6:0] rr [4];
   logic       restore_valid;
   logic [4:0] restore_arch;
   logic [6:0] restore_phys;
   logic       restore_done;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   int mt [32];
   int walk;
   int mrel_v [4];
   int mrel_r [4];
   int free_q [$];

   always #5 clk = ~clk;

   arch_map_table_release #(.COMMIT_WIDTH(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .commitValid0_i   (cv[0]),
      .commitValid1_i   (cv[1]),
      .commitValid2_i   (cv[2]),
      .commitValid3_i   (cv[3]),
      .commitHasDest0_i (ch[0]),
      .commitHasDest1_i (ch[1]),
      .commitHasDest2_i (ch[2]),
      .commitHasDest3_i (ch[3]),
      .commitArch0_i    (ca[0]),
      .commitArch1_i    (ca[1]),
      .commitArch2_i    (ca[2]),
      .commitArch3_i    (ca[3]),
      .commitPhys0_i    (cp[0]),
      .commitPhys1_i    (cp[1]),
      .commitPhys2_i    (cp[2]),
      .commitPhys3_i    (cp[3]),
      .commitReady_o    (commit_ready),
      .recover_i        (recover),
      .releaseValid0_o  (rv[0]),
      .releaseValid1_o  (rv[1]),
      .releaseValid2_o  (rv[2]),
      .releaseValid3_o  (rv[3]),
      .releaseReg0_o    (rr[0]),
      .releaseReg1_o    (rr[1]),
      .releaseReg2_o    (rr[2]),
      .releaseReg3_o    (rr[3]),
      .restoreValid_o   (restore_valid),
      .restoreArch_o    (restore_arch),
      .restorePhys_o    (restore_phys),
      .restoreDone_o    (restore_done)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) mt[i] = i;
      walk = -1;
      for (int n = 0; n < 4; n++) begin
         mrel_v[n] = 0;
         mrel_r[n] = 0;
      end
      free_q.delete();
      for (int t = 32; t < 128; t++) free_q.push_back(t);
   endfunction

   // Commits retire one lane at a time in program order; walk = -1 idle,
   // 0..31 restore position, 32 done pulse.
   function automatic void model_step();
      bit rdy;
      if (reset) begin
         model_reset();
      end else begin
         rdy = (walk < 0) || (walk == 32);
         for (int n = 0; n < 4; n++) begin
            mrel_v[n] = 0;
            mrel_r[n] = 0;
            if (cv[n] && ch[n] && rdy) begin
               mrel_v[n] = 1;
               mrel_r[n] = mt[ca[n]];
               mt[ca[n]] = int'(cp[n]);
               free_q.push_back(mrel_r[n]);
            end
         end
         if (recover && (walk != 32 || 1)) begin
            if (walk < 0 || walk >= 0) walk = 0;
         end else if (walk == 32) walk = -1;
         else if (walk >= 0) walk++;
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", int'(commit_ready), (walk >= 0 && walk < 32) ? 0 : 1);
         chk("restore_valid", int'(restore_valid), (walk >= 0 && walk < 32) ? 1 : 0);
         chk("restore_arch", int'(restore_arch), (walk >= 0 && walk < 32) ? walk : 0);
         chk("restore_phys", int'(restore_phys), (walk >= 0 && walk < 32) ? mt[walk] : 0);
         chk("restore_done", int'(restore_done), (walk == 32) ? 1 : 0);
         for (int n = 0; n < 4; n++) begin
            chk($sformatf("rel_valid%0d", n), int'(rv[n]), mrel_v[n]);
            chk($sformatf("rel_reg%0d", n), int'(rr[n]), mrel_r[n]);
         end
      end
   end

   task automatic clear_in();
      cv = '0;
      ch = '0;
      recover = 1'b0;
      for (int n = 0; n < 4; n++) begin
         ca[n] = '0;
         cp[n] = '0;
      end
   endtask

   task automatic lane(input int n, input bit v, input bit h, input int a, input int p);
      cv[n] = v;
      ch[n] = h;
      ca[n] = 5'(a);
      cp[n] = 7'(p);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      clear_in();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int lit [32];
      int k;
      int low;
      int cnt;
      bit seen;

      clear_in();
      model_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk_en = 1'b1;

      chk("rst_ready", int'(commit_ready), 1);
      chk("rst_rel_valid0", int'(rv[0]), 0);
      chk("rst_restore_valid", int'(restore_valid), 0);
      chk("rst_done", int'(restore_done), 0);

      lane(0, 1, 1, 3, 40);
      tick();
      chk("d1_rel_valid0", int'(rv[0]), 1);
      chk("d1_rel_reg0", int'(rr[0]), 3);

      lane(0, 1, 1, 3, 41);
      tick();
      chk("d2_rel_reg0", int'(rr[0]), 40);

      for (int n = 0; n < 4; n++) lane(n, 1, 1, 5, 50 + n);
      tick();
      chk("d3_rel_valid", int'({rv[3], rv[2], rv[1], rv[0]}), 15);
      chk("d3_rel_reg0", int'(rr[0]), 5);
      chk("d3_rel_reg1", int'(rr[1]), 50);
      chk("d3_rel_reg2", int'(rr[2]), 51);
      chk("d3_rel_reg3", int'(rr[3]), 52);

      lane(1, 1, 1, 7, 60);
      lane(3, 1, 1, 8, 61);
      tick();
      chk("d4_rel_valid", int'({rv[3], rv[2], rv[1], rv[0]}), 10);
      chk("d4_rel_reg1", int'(rr[1]), 7);
      chk("d4_rel_reg3", int'(rr[3]), 8);

      lane(3, 1, 0, 9, 62);
      tick();
      chk("d5_rel_valid", int'({rv[3], rv[2], rv[1], rv[0]}), 0);

      // Full walk: hand-written expected table contents.
      for (int i = 0; i < 32; i++) lit[i] = i;
      lit[3] = 41;
      lit[5] = 53;
      lit[7] = 60;
      lit[8] = 61;
      recover = 1'b1;
      tick();
      k = 0;
      low = 0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (!commit_ready) low++;
         if (restore_valid) begin
            chk("walk_arch", int'(restore_arch), k);
            chk("walk_phys", int'(restore_phys), lit[k % 32]);
            k++;
         end
         if (restore_done) seen = 1'b1;
         else tick();
      end
      chk("walk_ready_low", low, 32);
      chk("walk_done_seen", int'(seen), 1);
      tick();
      chk("walk_ready_after", int'(commit_ready), 1);

      // Restart at index 10.
      recover = 1'b1;
      tick();
      for (int c = 0; c < 40 && !(restore_valid && restore_arch == 5'd10); c++) tick();
      chk("restart_reach10", int'(restore_arch), 10);
      recover = 1'b1;
      tick();
      chk("restart_idx0", int'(restore_arch), 0);
      cnt = 0;
      for (int c = 0; c < 40 && !restore_done; c++) begin
         if (restore_valid) cnt++;
         tick();
      end
      chk("restart_len", cnt, 32);
      chk("restart_done", int'(restore_done), 1);
      tick();

      // Reset at index 20.
      recover = 1'b1;
      tick();
      for (int c = 0; c < 40 && !(restore_valid && restore_arch == 5'd20); c++) tick();
      chk("rst_mid_reach20", int'(restore_arch), 20);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_ready", int'(commit_ready), 1);
      chk("rst_mid_valid", int'(restore_valid), 0);
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (restore_done) seen = 1'b1;
         tick();
      end
      chk("rst_mid_no_done", int'(seen), 0);
      recover = 1'b1;
      tick();
      cnt = 0;
      for (int c = 0; c < 40 && !restore_done; c++) begin
         if (restore_valid && restore_phys == 7'(restore_arch)) cnt++;
         tick();
      end
      chk("rst_mid_identity", cnt, 32);
      tick();

      // Randomized traffic against the model.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 499) == 0);
         recover = !reset && ($urandom_range(0, 39) == 0);
         for (int n = 0; n < 4; n++) begin
            cv[n] = 1'($urandom_range(0, 1));
            ch[n] = ($urandom_range(0, 3) != 0);
            ca[n] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            if (cv[n] && ch[n] && !(walk >= 0 && walk < 32) && free_q.size() > 0)
               cp[n] = 7'(free_q.pop_front());
            else
               cp[n] = 7'($urandom_range(0, 127));
         end
         tick();
      end
      reset = 1'b0;
      tick();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
